// File: rtl/uart_bram_bridge.sv
// Byte-protocol bridge giving a serial host read/write access to a single-port BRAM.
// Frames: 'W' addr data -> 'K'; 'R' addr -> data bytes; anything else -> '?'.
module uart_bram_bridge #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic              CLK_100_I,
    input  logic              RST_N_I,
    input  logic [7:0]        RX_B_I,
    input  logic              RX_VALID_I,
    output logic [7:0]        TX_B_O,
    output logic              TX_VALID_O,
    input  logic              TX_READY_I,
    output logic [ADDR_W-1:0] BRAM_ADDR_O,
    output logic [DATA_W-1:0] BRAM_DATA_O,
    output logic              BRAM_WE_O,
    input  logic [DATA_W-1:0] BRAM_DATA_I,
    output logic              BUSY_O,
    output logic [7:0]        DROP_CNT_O
);

    localparam int unsigned NA    = ADDR_W / 8;
    localparam int unsigned ND    = DATA_W / 8;
    localparam int unsigned TMR_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [2:0]       NA_LAST  = 3'(NA - 1);
    localparam logic [2:0]       ND_LAST  = 3'(ND - 1);

    localparam logic [7:0] OP_WR   = 8'h57;
    localparam logic [7:0] OP_RD   = 8'h52;
    localparam logic [7:0] CH_ACK  = 8'h4B;
    localparam logic [7:0] CH_NACK = 8'h3F;

    typedef enum logic [3:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_DATA,
        S_WRITE,
        S_RD_ISSUE,
        S_RD_CAP,
        S_SEND,
        S_ACK,
        S_NACK
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              is_wr;
    logic [2:0]        byte_cnt;
    logic [TMR_W-1:0]  timer;
    logic [ADDR_W-1:0] addr_sr;
    logic [DATA_W-1:0] data_sr;
    logic [ADDR_W-1:0] addr_shifted;
    logic [DATA_W-1:0] data_shifted;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_wdata;
    logic [7:0]        drop_cnt;
    logic              drop_evt;
    logic              timed_out;

    assign addr_shifted = (addr_sr << 8) | ADDR_W'(RX_B_I);
    assign data_shifted = (data_sr << 8) | DATA_W'(RX_B_I);
    // A strobe arriving on the expiry cycle wins over the abort.
    assign timed_out    = (timer == TMR_LAST) && !RX_VALID_I;

    assign BRAM_ADDR_O = bram_addr;
    assign BRAM_DATA_O = bram_wdata;
    assign BUSY_O      = (state != S_IDLE);
    assign DROP_CNT_O  = drop_cnt;

    always_ff @(posedge CLK_100_I) begin
        if (!RST_N_I) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        drop_evt   = 1'b0;
        TX_VALID_O = 1'b0;
        TX_B_O     = '0;
        BRAM_WE_O  = 1'b0;
        case (state)
            S_IDLE: begin
                if (RX_VALID_I) begin
                    if (RX_B_I == OP_WR || RX_B_I == OP_RD) begin
                        state_next = S_GET_ADDR;
                    end else begin
                        state_next = S_NACK;
                        drop_evt   = 1'b1;
                    end
                end
            end
            S_GET_ADDR: begin
                if (RX_VALID_I) begin
                    if (byte_cnt == NA_LAST) begin
                        state_next = is_wr ? S_GET_DATA : S_RD_ISSUE;
                    end
                end else if (timed_out) begin
                    state_next = S_IDLE;
                    drop_evt   = 1'b1;
                end
            end
            S_GET_DATA: begin
                if (RX_VALID_I) begin
                    if (byte_cnt == ND_LAST) begin
                        state_next = S_WRITE;
                    end
                end else if (timed_out) begin
                    state_next = S_IDLE;
                    drop_evt   = 1'b1;
                end
            end
            S_WRITE: begin
                BRAM_WE_O  = 1'b1;
                drop_evt   = RX_VALID_I;
                state_next = S_ACK;
            end
            S_RD_ISSUE: begin
                drop_evt   = RX_VALID_I;
                state_next = S_RD_CAP;
            end
            S_RD_CAP: begin
                drop_evt   = RX_VALID_I;
                state_next = S_SEND;
            end
            S_SEND: begin
                TX_VALID_O = 1'b1;
                TX_B_O     = data_sr[DATA_W-1 -: 8];
                drop_evt   = RX_VALID_I;
                if (TX_READY_I && byte_cnt == ND_LAST) begin
                    state_next = S_IDLE;
                end
            end
            S_ACK: begin
                TX_VALID_O = 1'b1;
                TX_B_O     = CH_ACK;
                drop_evt   = RX_VALID_I;
                if (TX_READY_I) begin
                    state_next = S_IDLE;
                end
            end
            S_NACK: begin
                TX_VALID_O = 1'b1;
                TX_B_O     = CH_NACK;
                drop_evt   = RX_VALID_I;
                if (TX_READY_I) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_100_I) begin
        if (!RST_N_I) begin
            is_wr      <= 1'b0;
            byte_cnt   <= '0;
            timer      <= '0;
            addr_sr    <= '0;
            data_sr    <= '0;
            bram_addr  <= '0;
            bram_wdata <= '0;
            drop_cnt   <= '0;
        end else begin
            if (drop_evt && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
            case (state)
                S_IDLE: begin
                    if (RX_VALID_I) begin
                        is_wr    <= (RX_B_I == OP_WR);
                        byte_cnt <= '0;
                        timer    <= '0;
                    end
                end
                S_GET_ADDR: begin
                    if (RX_VALID_I) begin
                        timer   <= '0;
                        addr_sr <= addr_shifted;
                        if (byte_cnt == NA_LAST) begin
                            byte_cnt <= '0;
                            // Reads drive the address now; writes wait for the data.
                            if (!is_wr) begin
                                bram_addr <= addr_shifted;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                S_GET_DATA: begin
                    if (RX_VALID_I) begin
                        timer   <= '0;
                        data_sr <= data_shifted;
                        if (byte_cnt == ND_LAST) begin
                            byte_cnt   <= '0;
                            bram_addr  <= addr_sr;
                            bram_wdata <= data_shifted;
                        end else begin
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                S_RD_CAP: begin
                    data_sr  <= BRAM_DATA_I;
                    byte_cnt <= '0;
                end
                S_SEND: begin
                    if (TX_READY_I) begin
                        data_sr  <= data_sr << 8;
                        byte_cnt <= byte_cnt + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bram_bridge.sv
// Scoreboard bench for uart_bram_bridge: a 16/16 instance and a 24/32 instance,
// each with a registered-read BRAM model; expected TX bytes and writes are queued.
module tb_uart_bram_bridge;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // instance 0: ADDR_W=16, DATA_W=16
    logic [7:0]  rx_b0 = '0;
    logic        rx_v0 = 1'b0;
    logic        rdy0 = 1'b1;
    logic [7:0]  tx_b0;
    logic        tx_valid0;
    logic [15:0] addr0;
    logic [15:0] wdata0;
    logic        we0;
    logic [15:0] rdata0 = '0;
    logic        busy0;
    logic [7:0]  drop0;
    logic [15:0] mem0 [256];

    // instance 1: ADDR_W=24, DATA_W=32
    logic [7:0]  rx_b1 = '0;
    logic        rx_v1 = 1'b0;
    logic        rdy1 = 1'b1;
    logic [7:0]  tx_b1;
    logic        tx_valid1;
    logic [23:0] addr1;
    logic [31:0] wdata1;
    logic        we1;
    logic [31:0] rdata1 = '0;
    logic        busy1;
    logic [7:0]  drop1;
    logic [31:0] mem1 [256];

    logic [7:0]  tx_q0 [$];
    logic [7:0]  tx_q1 [$];
    logic [63:0] wr_q0 [$];
    logic [63:0] wr_q1 [$];

    uart_bram_bridge #(.ADDR_W(16), .DATA_W(16), .TIMEOUT_CYC(100)) dut0 (
        .CLK_100_I(clk), .RST_N_I(rst_n),
        .RX_B_I(rx_b0), .RX_VALID_I(rx_v0),
        .TX_B_O(tx_b0), .TX_VALID_O(tx_valid0), .TX_READY_I(rdy0),
        .BRAM_ADDR_O(addr0), .BRAM_DATA_O(wdata0), .BRAM_WE_O(we0),
        .BRAM_DATA_I(rdata0), .BUSY_O(busy0), .DROP_CNT_O(drop0)
    );

    uart_bram_bridge #(.ADDR_W(24), .DATA_W(32), .TIMEOUT_CYC(100)) dut1 (
        .CLK_100_I(clk), .RST_N_I(rst_n),
        .RX_B_I(rx_b1), .RX_VALID_I(rx_v1),
        .TX_B_O(tx_b1), .TX_VALID_O(tx_valid1), .TX_READY_I(rdy1),
        .BRAM_ADDR_O(addr1), .BRAM_DATA_O(wdata1), .BRAM_WE_O(we1),
        .BRAM_DATA_I(rdata1), .BUSY_O(busy1), .DROP_CNT_O(drop1)
    );

    always @(posedge clk) begin
        if (we0) mem0[addr0[7:0]] <= wdata0;
        rdata0 <= mem0[addr0[7:0]];
        if (we1) mem1[addr1[7:0]] <= wdata1;
        rdata1 <= mem1[addr1[7:0]];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitors: sampled mid-cycle, a transfer happens at the next rising edge.
    always @(negedge clk) begin
        if (tx_valid0 && rdy0) begin
            if (tx_q0.size() == 0) check("tx0_unexpected", 64'(tx_q0.size()), 64'd1);
            else check("tx0_byte", {56'd0, tx_b0}, {56'd0, tx_q0.pop_front()});
        end
        if (we0) begin
            if (wr_q0.size() == 0) check("we0_unexpected", 64'(wr_q0.size()), 64'd1);
            else check("we0_addr_data", {32'd0, addr0, wdata0}, wr_q0.pop_front());
        end
        if (tx_valid1 && rdy1) begin
            if (tx_q1.size() == 0) check("tx1_unexpected", 64'(tx_q1.size()), 64'd1);
            else check("tx1_byte", {56'd0, tx_b1}, {56'd0, tx_q1.pop_front()});
        end
        if (we1) begin
            if (wr_q1.size() == 0) check("we1_unexpected", 64'(wr_q1.size()), 64'd1);
            else check("we1_addr_data", {8'd0, addr1, wdata1}, wr_q1.pop_front());
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after the strobe.
    task automatic send(input int inst, input logic [7:0] b);
        if (inst == 0) begin rx_b0 = b; rx_v0 = 1'b1; end
        else begin rx_b1 = b; rx_v1 = 1'b1; end
        @(posedge clk); #1;
        rx_v0 = 1'b0;
        rx_v1 = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain(input int inst, input int budget);
        int k = 0;
        while (k < budget && ((inst == 0) ? tx_q0.size() : tx_q1.size()) != 0) begin
            step(1);
            k++;
        end
        step(1);
        check((inst == 0) ? "drain0" : "drain1",
              64'((inst == 0) ? tx_q0.size() : tx_q1.size()), 64'd0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step(3);
        check("reset_outputs", {13'd0, tx_valid0, tx_b0, we0, addr0, wdata0, busy0, drop0}, 64'd0);
        rst_n = 1'b1;
        step(1);

        // write 0x1234 <= 0xBEEF, WE one cycle after last byte, 'K' one after that
        wr_q0.push_back(64'h1234_BEEF);
        tx_q0.push_back(8'h4B);
        send(0, 8'h57); send(0, 8'h12); send(0, 8'h34); send(0, 8'hBE);
        check("busy_during_frame", {63'd0, busy0}, 64'd1);
        send(0, 8'hEF);
        check("wr_we_n1", {63'd0, we0}, 64'd1);
        check("wr_addr", {48'd0, addr0}, 64'h1234);
        check("wr_data", {48'd0, wdata0}, 64'hBEEF);
        step(1);
        check("ack_valid_n2", {63'd0, tx_valid0}, 64'd1);
        check("ack_byte_n2", {56'd0, tx_b0}, 64'h4B);
        check("we_single_pulse", {63'd0, we0}, 64'd0);
        step(1);
        check("busy_after_ack", {63'd0, busy0}, 64'd0);

        // read back, ready high: BE, EF on consecutive cycles
        tx_q0.push_back(8'hBE);
        tx_q0.push_back(8'hEF);
        send(0, 8'h52); send(0, 8'h12); send(0, 8'h34);
        check("rd_addr_n1", {48'd0, addr0}, 64'h1234);
        check("rd_novalid_n1", {63'd0, tx_valid0}, 64'd0);
        step(1);
        check("rd_novalid_n2", {63'd0, tx_valid0}, 64'd0);
        step(1);
        check("rd_b0_n3", {55'd0, tx_valid0, tx_b0}, 64'h1BE);
        step(1);
        check("rd_b1_n4", {55'd0, tx_valid0, tx_b0}, 64'h1EF);
        step(1);
        check("rd_done", {62'd0, busy0, tx_valid0}, 64'd0);
        check("drop_zero", {56'd0, drop0}, 64'd0);

        // bad opcode
        tx_q0.push_back(8'h3F);
        send(0, 8'h41);
        step(2);
        check("nack_drop", {56'd0, drop0}, 64'd1);
        check("nack_idle", {63'd0, busy0}, 64'd0);

        // strobe on the expiry cycle counts, then a full silent timeout aborts
        send(0, 8'h57);
        step(99);
        send(0, 8'h00);
        check("late_strobe_kept", {63'd0, busy0}, 64'd1);
        step(99);
        check("timeout_not_yet", {63'd0, busy0}, 64'd1);
        step(1);
        check("timeout_idle", {63'd0, busy0}, 64'd0);
        check("timeout_drop", {56'd0, drop0}, 64'd2);

        // stalled reply: TX_B_O stable, strobe during SEND dropped
        rdy0 = 1'b0;
        tx_q0.push_back(8'hBE);
        tx_q0.push_back(8'hEF);
        send(0, 8'h52); send(0, 8'h12); send(0, 8'h34);
        for (int k = 0; k < 10 && !tx_valid0; k++) step(1);
        check("stall_valid", {63'd0, tx_valid0}, 64'd1);
        for (int k = 0; k < 20; k++) begin
            if (k == 10) send(0, 8'h99);
            else step(1);
            check("stall_stable", {55'd0, tx_valid0, tx_b0}, 64'h1BE);
        end
        check("send_strobe_drop", {56'd0, drop0}, 64'd3);
        rdy0 = 1'b1;
        drain(0, 20);
        check("stall_done_idle", {63'd0, busy0}, 64'd0);

        // reset in GET_DATA: no write, all outputs back to reset values
        send(0, 8'h57); send(0, 8'h00); send(0, 8'h01); send(0, 8'hAA);
        rst_n = 1'b0;
        step(1);
        check("midframe_reset", {13'd0, tx_valid0, tx_b0, we0, addr0, wdata0, busy0, drop0}, 64'd0);
        step(1);
        rst_n = 1'b1;
        step(3);
        check("after_reset_quiet", {62'd0, busy0, we0}, 64'd0);

        // drop counter saturates at 0xFF
        for (int k = 0; k < 254; k++) begin
            tx_q0.push_back(8'h3F);
            send(0, 8'h41);
            step(1);
        end
        check("drop_254", {56'd0, drop0}, 64'hFE);
        for (int k = 0; k < 6; k++) begin
            tx_q0.push_back(8'h3F);
            send(0, 8'h41);
            step(1);
        end
        check("drop_saturated", {56'd0, drop0}, 64'hFF);

        // wide instance: write 0x010203 <= 0xDEADBEEF and read it back
        wr_q1.push_back(64'h010203_DEADBEEF);
        tx_q1.push_back(8'h4B);
        send(1, 8'h57); send(1, 8'h01); send(1, 8'h02); send(1, 8'h03);
        send(1, 8'hDE); send(1, 8'hAD); send(1, 8'hBE); send(1, 8'hEF);
        check("w_we", {63'd0, we1}, 64'd1);
        drain(1, 20);
        tx_q1.push_back(8'hDE);
        tx_q1.push_back(8'hAD);
        tx_q1.push_back(8'hBE);
        tx_q1.push_back(8'hEF);
        send(1, 8'h52); send(1, 8'h01); send(1, 8'h02); send(1, 8'h03);
        check("w_rd_addr", {40'd0, addr1}, 64'h010203);
        drain(1, 20);
        check("w_idle", {55'd0, busy1, drop1}, 64'd0);

        check("tx0_left", 64'(tx_q0.size()), 64'd0);
        check("wr0_left", 64'(wr_q0.size()), 64'd0);
        check("wr1_left", 64'(wr_q1.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
